// File: rtl/strobe_serial_tx.sv
// Strobe-paced serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Optional parity bit is built in when STROBE_SERIAL_TX_PARITY_EN is defined.
module strobe_serial_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  timer_enable,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

`ifdef STROBE_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_serial;
  logic                  r_done;
`ifdef STROBE_SERIAL_TX_PARITY_EN
  logic                  r_parity;
`endif

  logic w_idle;
  logic w_last_bit;
  logic w_last_stop;

  assign w_idle      = (r_state == S_IDLE);
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_last_stop = (r_stop_cnt == LAST_STOP);

  assign tx_ready     = w_idle;
  assign busy         = !w_idle;
  assign timer_enable = !w_idle;
  assign serial_out   = r_serial;
  assign frame_done   = r_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_serial   <= 1'b1;
      r_done     <= 1'b0;
`ifdef STROBE_SERIAL_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // Strobes seen while idle (including the accept edge) are deliberately dropped.
        S_IDLE: begin
          if (tx_valid) begin
            r_shift    <= tx_data;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_serial   <= 1'b0;
            r_state    <= S_START;
`ifdef STROBE_SERIAL_TX_PARITY_EN
            r_parity   <= ^tx_data;
`endif
          end
        end
        S_START: begin
          if (strobe) begin
            r_serial <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (strobe) begin
            if (w_last_bit) begin
`ifdef STROBE_SERIAL_TX_PARITY_EN
              r_serial <= r_parity;
              r_state  <= S_PARITY;
`else
              r_serial <= 1'b1;
              r_state  <= S_STOP;
`endif
            end else begin
              r_serial  <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
`ifdef STROBE_SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (strobe) begin
            r_serial <= 1'b1;
            r_state  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (strobe) begin
            if (w_last_stop) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_serial_tx.sv
// Scoreboard bench: two transmitters (1 and 2 stop bits); expected line levels are queued per frame
// at issue time and popped by a monitor at every bit-ending strobe.
module tb_strobe_serial_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] strobe_en;
  logic [1:0] strobe;
  logic [1:0] strobe_cnt;
  logic [1:0] tx_valid;
  logic [7:0] tx_data0, tx_data1;
  logic [1:0] tx_ready, serial_out, busy, timer_enable, frame_done;

  always #5 clk = ~clk;

  // Free-running bit tick: one strobe every 4 clocks per enabled channel.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) strobe_cnt <= 2'd0;
    else        strobe_cnt <= strobe_cnt + 2'd1;
  end
  assign strobe[0] = strobe_en[0] && (strobe_cnt == 2'd3);
  assign strobe[1] = strobe_en[1] && (strobe_cnt == 2'd3);

  strobe_serial_tx #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .strobe(strobe[0]), .tx_data(tx_data0), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .serial_out(serial_out[0]), .busy(busy[0]),
    .timer_enable(timer_enable[0]), .frame_done(frame_done[0])
  );

  strobe_serial_tx #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .strobe(strobe[1]), .tx_data(tx_data1), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .serial_out(serial_out[1]), .busy(busy[1]),
    .timer_enable(timer_enable[1]), .frame_done(frame_done[1])
  );

  // Queue entry: {last bit of frame, expected line level}
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] pend_done = 2'b00;
  int errors = 0;
  int checks = 0;
  int done_seen [2] = '{0, 0};
  int done_exp  [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int i, input logic [1:0] e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_frame(input int i, input logic [7:0] d);
    int stops;
    stops = i + 1;
    qpush(i, 2'b00);
    for (int b = 0; b < 8; b++) qpush(i, {1'b0, d[b]});
`ifdef STROBE_SERIAL_TX_PARITY_EN
    qpush(i, {1'b0, ^d});
`endif
    for (int s = 0; s < stops; s++) qpush(i, {(s == stops - 1), 1'b1});
    done_exp[i]++;
    $display("issue ch%0d data=%02h bits=%0d", i, d, qsize(i));
  endtask

  // Monitor: sample mid-cycle; each strobe seen while busy ends the current bit.
  always @(negedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] e;
        if (pend_done[i])
          check($sformatf("frame_done%0d{done,ready,busy}", i),
                {frame_done[i], tx_ready[i], busy[i]}, 3'b110);
        else if (frame_done[i])
          check($sformatf("spurious_done%0d", i), frame_done[i], 1'b0);
        if (frame_done[i]) done_seen[i]++;
        pend_done[i] = 1'b0;
        if (strobe[i] && busy[i]) begin
          if (qsize(i) == 0) begin
            check($sformatf("extra_bit%0d", i), 1, 0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("serial%0d_bit%0d", i, qsize(i)), serial_out[i], e[0]);
            check($sformatf("timer_enable%0d", i), timer_enable[i], 1'b1);
            $display("bit ch%0d level=%0b exp=%0b", i, serial_out[i], e[0]);
            if (e[1]) pend_done[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_done(input int i, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (qsize(i) == 0 && !busy[i] && !pend_done[i]) begin ok = 1; break; end
    end
    check($sformatf("frame_timeout%0d", i), ok, 1'b1);
    @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] d);
    push_frame(0, d);
    tx_data0    = d;
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    tx_data0    = ~d;
    check("accept0{busy,serial}", {busy[0], serial_out[0]}, 2'b10);
  endtask

  task automatic wait_pops0(input int target, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (q0.size() <= target) begin ok = 1; break; end
    end
    check("pop_timeout0", ok, 1'b1);
  endtask

  initial begin
    logic held;
    int   changes;
    bit   ok;
    n_rst     = 1'b0;
    strobe_en = 2'b11;
    tx_valid  = 2'b00;
    tx_data0  = 8'h00;
    tx_data1  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset0{so,rdy,busy,te,fd}", {serial_out[0], tx_ready[0], busy[0], timer_enable[0], frame_done[0]}, 5'b11000);
    check("reset1{so,rdy,busy,te,fd}", {serial_out[1], tx_ready[1], busy[1], timer_enable[1], frame_done[1]}, 5'b11000);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    send0(8'hA5);
    wait_done(0, 300);
    send0(8'h07);
    wait_done(0, 300);

    // Strobe coincident with the accept edge must not shorten the start bit.
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (strobe[0]) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check("strobe_align", ok, 1'b1);
    send0(8'h3C);
    wait_done(0, 300);

    // Stall inside DATA bit 3.
    send0(8'h5A);
    wait_pops0(q0.size() - 4, 100);
    strobe_en[0] = 1'b0;
    held    = serial_out[0];
    changes = 0;
    repeat (50) begin
      @(negedge clk);
      if (serial_out[0] !== held || !busy[0]) changes++;
    end
    check("stall_changes", changes, 0);
    @(posedge clk); #1;
    strobe_en[0] = 1'b1;
    wait_done(0, 300);

    // Asynchronous reset during DATA bit 3 aborts the frame with no done pulse.
    send0(8'h96);
    wait_pops0(q0.size() - 4, 100);
    #2;
    n_rst = 1'b0;
    #1;
    check("midreset0{so,rdy,busy,te,fd}", {serial_out[0], tx_ready[0], busy[0], timer_enable[0], frame_done[0]}, 5'b11000);
    q0.delete();
    done_exp[0]--;
    pend_done = 2'b00;
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle0", {busy[0], serial_out[0]}, 2'b01);

    // Two stop bits, tx_valid held: second word accepted one cycle after frame_done.
    push_frame(1, 8'h01);
    tx_data1    = 8'h01;
    tx_valid[1] = 1'b1;
    @(posedge clk); #1;
    tx_data1 = 8'hFF;
    push_frame(1, 8'hFF);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (frame_done[1]) begin ok = 1; break; end
    end
    check("b2b_done_timeout", ok, 1'b1);
    @(negedge clk);
    check("b2b_accept{busy,serial}", {busy[1], serial_out[1]}, 2'b10);
    tx_valid[1] = 1'b0;
    wait_done(1, 300);

    repeat (10) @(posedge clk);
    #1;
    check("done_count0", done_seen[0], done_exp[0]);
    check("done_count1", done_seen[1], done_exp[1]);
    check("queue_empty", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
